// File: rtl/imem_arbiter.sv
// Two-port arbiter in front of a single-port instruction memory: fetch has
// fixed priority, debug is guaranteed service after WAIT_MAX denied cycles.
module imem_arbiter #(
  parameter int AW       = 6,
  parameter int DW       = 32,
  parameter int WAIT_MAX = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_a,
  output logic          mem_we,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, RSP_F, RSP_D} rsp_e;

  rsp_e       rsp_sel;
  logic [3:0] wait_cnt;
  logic       d_win;

  // Once debug has been starved long enough it takes the next contended cycle.
  assign d_win = (wait_cnt >= 4'(WAIT_MAX));

  assign d_gnt = ~reset & d_req & (~f_req | d_win);
  assign f_gnt = ~reset & f_req & ~(d_req & d_win);

  assign mem_a  = d_gnt ? d_addr : f_addr;
  assign mem_we = d_gnt & d_we;
  assign mem_wd = d_wdata;

  assign f_rvalid = (rsp_sel == RSP_F);
  assign d_rvalid = (rsp_sel == RSP_D);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_sel  <= IDLE;
      wait_cnt <= '0;
      f_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      if (f_gnt) begin
        rsp_sel <= RSP_F;
        f_rdata <= mem_rd;
      end else if (d_gnt && !d_we) begin
        rsp_sel <= RSP_D;
        d_rdata <= mem_rd;
      end else begin
        rsp_sel <= IDLE;
      end

      if (d_req && !d_gnt) begin
        if (!d_win) wait_cnt <= wait_cnt + 4'd1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized bench for imem_arbiter: a word-level model of memory contents,
// arbitration and one-cycle read responses predicts every cycle.
module tb_imem_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int WM = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_req, f_gnt, f_rvalid;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [AW-1:0] mem_a;
  logic          mem_we;
  logic [DW-1:0] mem_wd, mem_rd;

  imem_arbiter #(.AW(AW), .DW(DW), .WAIT_MAX(WM)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // memory instance seen by the DUT, and the model's own copy of its contents
  logic [DW-1:0] mem     [64];
  logic [DW-1:0] ref_mem [64];
  assign mem_rd = mem[mem_a];

  int          n_chk = 0, n_pass = 0;
  int          wait_n;
  logic        exp_fv, exp_dv, last_ef, last_ed;
  logic [31:0] exp_fd, exp_dd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic mdl_reset();
    exp_fv = 0; exp_dv = 0; exp_fd = '0; exp_dd = '0;
    wait_n = 0; last_ef = 0; last_ed = 0;
  endtask

  // one clock cycle with the currently driven inputs
  task automatic step();
    logic        ef, ed, sw;
    logic [5:0]  sa;
    logic [31:0] sd;
    @(negedge clk); #1;
    ed = d_req && (!f_req || wait_n >= WM);
    ef = f_req && !ed;
    chk("f_gnt", 32'(f_gnt), 32'(ef));
    chk("d_gnt", 32'(d_gnt), 32'(ed));
    chk("mem_we", 32'(mem_we), 32'(ed && d_we));
    if (ef || ed) chk("mem_a", 32'(mem_a), 32'(ed ? d_addr : f_addr));
    sw = mem_we; sa = mem_a; sd = mem_wd;
    @(posedge clk);
    if (sw) mem[sa] = sd;
    exp_fv = ef;
    if (ef) exp_fd = ref_mem[f_addr];
    exp_dv = ed && !d_we;
    if (exp_dv) exp_dd = ref_mem[d_addr];
    if (ed && d_we) ref_mem[d_addr] = d_wdata;
    if (d_req && !ed) wait_n = (wait_n + 1 > WM) ? WM : wait_n + 1;
    else wait_n = 0;
    last_ef = ef; last_ed = ed;
    #1;
    chk("f_rvalid", 32'(f_rvalid), 32'(exp_fv));
    chk("d_rvalid", 32'(d_rvalid), 32'(exp_dv));
    chk("f_rdata", f_rdata, exp_fd);
    chk("d_rdata", d_rdata, exp_dd);
    chk("wait_cnt", 32'(dut.wait_cnt), 32'(wait_n));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'(i + 'h100);
      ref_mem[i] = 32'(i + 'h100);
    end
    reset = 1; f_req = 1; f_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mdl_reset();
    #12;
    chk("rst_f_gnt", 32'(f_gnt), 0);
    chk("rst_f_rvalid", 32'(f_rvalid), 0);
    chk("rst_d_rvalid", 32'(d_rvalid), 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_wait", 32'(dut.wait_cnt), 0);
    @(negedge clk);
    reset = 0; f_req = 0;

    // fetch stream
    for (int i = 0; i < 3; i++) begin
      f_req = 1; f_addr = 6'(i);
      step();
    end
    f_req = 0;
    step();

    // debug write, then fetch of the same word
    d_req = 1; d_we = 1; d_addr = 6'h20; d_wdata = 32'hDEADBEEF;
    step();
    d_req = 0; d_we = 0;
    f_req = 1; f_addr = 6'h20;
    step();
    chk("wr_readback", f_rdata, 32'hDEADBEEF);
    f_req = 0;
    step();

    // contention: debug must win on the fourth contended cycle
    f_req = 1; d_req = 1; d_we = 0; d_addr = 6'h3F;
    for (int i = 0; i < 7; i++) begin
      f_addr = 6'(i + 8);
      step();
      if (i == 3) chk("starve_gnt", 32'(last_ed), 1);
      if (last_ed) d_req = 0;
    end
    chk("starve_data", d_rdata, 32'h13F);
    f_req = 0;
    step();

    // address boundary: top word on debug, bottom word on fetch
    d_req = 1; d_addr = 6'h3F;
    step();
    d_req = 0; f_req = 1; f_addr = 6'h00;
    step();
    chk("bnd_f", f_rdata, 32'h100);
    chk("bnd_d", d_rdata, 32'h13F);
    f_req = 0;
    step();

    // reset in the middle of a granted fetch drops the response
    @(negedge clk);
    f_req = 1; f_addr = 6'h05;
    #1 chk("mid_f_gnt", 32'(f_gnt), 1);
    #1 reset = 1;
    #1 chk("mid_gnt_off", 32'(f_gnt), 0);
    @(posedge clk); #1;
    chk("mid_f_rvalid", 32'(f_rvalid), 0);
    chk("mid_f_rdata", f_rdata, 0);
    chk("mid_wait", 32'(dut.wait_cnt), 0);
    @(negedge clk);
    reset = 0; f_req = 0;
    mdl_reset();
    step();
    step();

    // random traffic, requests held until granted
    for (int n = 0; n < 1000; n++) begin
      if (!(f_req && !last_ef)) begin
        f_req = 1'($urandom);
        f_addr = 6'($urandom);
      end
      if (!(d_req && !last_ed)) begin
        d_req = 1'($urandom);
        d_we = ($urandom_range(0, 3) == 0);
        d_addr = 6'($urandom);
        d_wdata = $urandom;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
